decode_execute_stage: RTL and testbench

- Combined decode, control and execute stage of the single-cycle BRISC-V RV32I core.
- Sits between fetch_unit and memory_unit/writeback_unit.
- Splits the instruction into fields, reads and writes the 32-entry register file, and generates control signals from the opcode.
- Computes the ALU result, branch decision and the branch, JAL and JALR targets in the same cycle the instruction is presented.

---
 rtl/riscv_pkg.sv | 138 +++++++++++++
 rtl/regfile.sv | 33 +++
 rtl/decode_execute_stage.sv | 178 +++++++++++++++++
 tb/tb_decode_execute_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and the opcode-to-control decode for the decode/execute stage.
// Latency: pure definitions and combinational helpers; no backpressure.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ALU_R      = 3'b000,
      ALU_I      = 3'b001,
      ALU_BRANCH = 3'b010,
      ALU_JUMP   = 3'b011,
      ALU_LOAD   = 3'b100,
      ALU_STORE  = 3'b101,
      ALU_LUI    = 3'b110,
      ALU_AUIPC  = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      NPC_SEQ    = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JAL    = 2'b10,
      NPC_JALR   = 2'b11
   } next_pc_sel_e;

   typedef enum logic [1:0] {
      OPA_RS1  = 2'b00,
      OPA_PC4  = 2'b01,
      OPA_PC   = 2'b10,
      OPA_ZERO = 2'b11
   } opa_sel_e;

   typedef enum logic [1:0] {
      EXT_I = 2'b00,
      EXT_S = 2'b01,
      EXT_U = 2'b10
   } ext_sel_e;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      alu_op_e      alu_op;
      opa_sel_e     opa;
      logic         opb;
      ext_sel_e     ext;
      next_pc_sel_e npc;
      logic         mem_read;
      logic         mem_to_reg;
      logic         mem_write;
      logic         reg_write;
      logic         branch_op;
   } ctrl_t;

   // Unknown opcodes fall through to an all-zero bundle, i.e. a harmless no-op.
   function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
      ctrl_t c;
      c = '0;
      case (opcode)
         OP_R: begin
            c.alu_op    = ALU_R;
            c.reg_write = 1'b1;
         end
         OP_I: begin
            c.alu_op    = ALU_I;
            c.opb       = 1'b1;
            c.reg_write = 1'b1;
         end
         OP_LOAD: begin
            c.alu_op     = ALU_LOAD;
            c.opb        = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         OP_STORE: begin
            c.alu_op    = ALU_STORE;
            c.opb       = 1'b1;
            c.ext       = EXT_S;
            c.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            c.alu_op    = ALU_BRANCH;
            c.npc       = NPC_BRANCH;
            c.branch_op = 1'b1;
         end
         OP_JAL: begin
            c.alu_op    = ALU_JUMP;
            c.opa       = OPA_PC4;
            c.npc       = NPC_JAL;
            c.reg_write = 1'b1;
         end
         OP_JALR: begin
            c.alu_op    = ALU_JUMP;
            c.opa       = OPA_PC4;
            c.npc       = NPC_JALR;
            c.reg_write = 1'b1;
         end
         OP_LUI: begin
            c.alu_op    = ALU_LUI;
            c.opa       = OPA_ZERO;
            c.opb       = 1'b1;
            c.ext       = EXT_U;
            c.reg_write = 1'b1;
         end
         OP_AUIPC: begin
            c.alu_op    = ALU_AUIPC;
            c.opa       = OPA_PC;
            c.opb       = 1'b1;
            c.ext       = EXT_U;
            c.reg_write = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry register file: two asynchronous read ports, one write port on the rising clock edge.
// Latency: reads combinational, writes visible next cycle; no backpressure; x0 is never written.
module regfile #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write,
   input  logic [4:0]            write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [4:0]            read_sel1,
   input  logic [4:0]            read_sel2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   logic [DATA_WIDTH-1:0] regs [32];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (write && (write_reg != 5'd0)) begin
         regs[write_reg] <= write_data;
      end
   end

   // No write-to-read bypass: a same-cycle read returns the pre-write value.
   assign read_data1 = regs[read_sel1];
   assign read_data2 = regs[read_sel2];

endmodule

// File: rtl/decode_execute_stage.sv
// Single-cycle RV32I decode, control and execute: fields, regfile, immediates, ALU, branch and jump targets.
// Latency: combinational from instruction/PC/regfile, regfile writes on clock; no backpressure.
module decode_execute_stage
   import riscv_pkg::*;
#(
   parameter int CORE         = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [31:0]             instruction,
   input  logic [ADDRESS_BITS-1:0] PC,
   input  logic                    write,
   input  logic [4:0]              write_reg,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic                    report,
   output logic [6:0]              opcode,
   output logic [2:0]              funct3,
   output logic [6:0]              funct7,
   output logic [4:0]              rd,
   output logic [DATA_WIDTH-1:0]   rs1_data,
   output logic [DATA_WIDTH-1:0]   rs2_data,
   output logic [DATA_WIDTH-1:0]   extend_imm,
   output logic [ADDRESS_BITS-1:0] branch_target,
   output logic [ADDRESS_BITS-1:0] JAL_target,
   output logic [ADDRESS_BITS-1:0] JALR_target,
   output logic [DATA_WIDTH-1:0]   ALU_result,
   output logic                    zero,
   output logic                    branch,
   output logic                    memRead,
   output logic                    memtoReg,
   output logic                    memWrite,
   output logic                    regWrite,
   output logic                    branch_op,
   output logic [2:0]              ALUOp,
   output logic [1:0]              next_PC_sel,
   output logic [1:0]              operand_A_sel,
   output logic                    operand_B_sel
);

   ctrl_t                   ctrl;
   logic [4:0]              rs1;
   logic [4:0]              rs2;
   logic [DATA_WIDTH-1:0]   imm_i;
   logic [DATA_WIDTH-1:0]   imm_s;
   logic [DATA_WIDTH-1:0]   imm_u;
   logic [ADDRESS_BITS-1:0] b_off;
   logic [ADDRESS_BITS-1:0] j_off;
   logic [DATA_WIDTH-1:0]   jalr_sum;
   logic [DATA_WIDTH-1:0]   pc_ext;
   logic [DATA_WIDTH-1:0]   pc_plus4;
   logic [DATA_WIDTH-1:0]   op_a;
   logic [DATA_WIDTH-1:0]   op_b;
   logic [4:0]              shamt;
   logic                    alu_branch;

   assign opcode = instruction[6:0];
   assign rd     = instruction[11:7];
   assign funct3 = instruction[14:12];
   assign rs1    = instruction[19:15];
   assign rs2    = instruction[24:20];
   assign funct7 = instruction[31:25];

   assign ctrl = decode_ctrl(opcode);

   assign memRead       = ctrl.mem_read;
   assign memtoReg      = ctrl.mem_to_reg;
   assign memWrite      = ctrl.mem_write;
   assign regWrite      = ctrl.reg_write;
   assign branch_op     = ctrl.branch_op;
   assign ALUOp         = ctrl.alu_op;
   assign next_PC_sel   = ctrl.npc;
   assign operand_A_sel = ctrl.opa;
   assign operand_B_sel = ctrl.opb;

   regfile #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_regfile (
      .clock      (clock),
      .reset      (reset),
      .write      (write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_sel1  (rs1),
      .read_sel2  (rs2),
      .read_data1 (rs1_data),
      .read_data2 (rs2_data)
   );

   assign imm_i = DATA_WIDTH'($signed(instruction[31:20]));
   assign imm_s = DATA_WIDTH'($signed({instruction[31:25], instruction[11:7]}));
   assign imm_u = DATA_WIDTH'($signed({instruction[31:12], 12'b0}));

   always_comb begin
      extend_imm = imm_i;
      case (ctrl.ext)
         EXT_S:   extend_imm = imm_s;
         EXT_U:   extend_imm = imm_u;
         default: extend_imm = imm_i;
      endcase
   end

   // Branch and JAL offsets are scattered across the word and always even.
   assign b_off = ADDRESS_BITS'($signed({instruction[31], instruction[7],
                                          instruction[30:25], instruction[11:8], 1'b0}));
   assign j_off = ADDRESS_BITS'($signed({instruction[31], instruction[19:12],
                                          instruction[20], instruction[30:21], 1'b0}));

   assign branch_target = PC + b_off;
   assign JAL_target    = PC + j_off;
   assign jalr_sum      = rs1_data + imm_i;
   assign JALR_target   = {jalr_sum[ADDRESS_BITS-1:1], 1'b0};

   assign pc_ext   = DATA_WIDTH'(PC);
   assign pc_plus4 = pc_ext + DATA_WIDTH'(4);

   always_comb begin
      op_a = rs1_data;
      case (ctrl.opa)
         OPA_PC4:  op_a = pc_plus4;
         OPA_PC:   op_a = pc_ext;
         OPA_ZERO: op_a = '0;
         default:  op_a = rs1_data;
      endcase
   end

   assign op_b  = ctrl.opb ? extend_imm : rs2_data;
   assign shamt = op_b[4:0];

   always_comb begin
      ALU_result = '0;
      case (ctrl.alu_op)
         ALU_R, ALU_I: begin
            case (funct3)
               // SUB exists only in the register form; ADDI reuses funct7 bits as immediate.
               F3_ADD:  ALU_result = (ctrl.alu_op == ALU_R && funct7[5]) ? op_a - op_b
                                                                          : op_a + op_b;
               F3_SLL:  ALU_result = op_a << shamt;
               F3_SLT:  ALU_result = DATA_WIDTH'($signed(op_a) < $signed(op_b));
               F3_SLTU: ALU_result = DATA_WIDTH'(op_a < op_b);
               F3_XOR:  ALU_result = op_a ^ op_b;
               F3_SR: begin
                  if (funct7[5]) ALU_result = $signed(op_a) >>> shamt;
                  else           ALU_result = op_a >> shamt;
               end
               F3_OR:   ALU_result = op_a | op_b;
               F3_AND:  ALU_result = op_a & op_b;
            endcase
         end
         ALU_BRANCH: ALU_result = op_a - op_b;
         ALU_JUMP:   ALU_result = op_a;
         default:    ALU_result = op_a + op_b;
      endcase
   end

   assign zero = (ALU_result == '0);

   always_comb begin
      alu_branch = 1'b0;
      case (funct3)
         F3_BEQ:  alu_branch = (op_a == op_b);
         F3_BNE:  alu_branch = (op_a != op_b);
         F3_BLT:  alu_branch = ($signed(op_a) <  $signed(op_b));
         F3_BGE:  alu_branch = ($signed(op_a) >= $signed(op_b));
         F3_BLTU: alu_branch = (op_a <  op_b);
         F3_BGEU: alu_branch = (op_a >= op_b);
         default: alu_branch = 1'b0;
      endcase
   end

   assign branch = ctrl.branch_op & alu_branch;

   // report and CORE only feed simulation statistics; the low jalr bit is forced clear.
   logic unused_sim;
   assign unused_sim = ^{report, jalr_sum[DATA_WIDTH-1:ADDRESS_BITS], jalr_sum[0], (CORE < 0)};

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_decode_execute_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instruction = 32'h0000_0013;
   logic [19:0] PC = '0;
   logic        write = 1'b0;
   logic [4:0]  write_reg = '0;
   logic [31:0] write_data = '0;
   logic        report = 1'b0;

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3, ALUOp;
   logic [4:0]  rd;
   logic [31:0] rs1_data, rs2_data, extend_imm, ALU_result;
   logic [19:0] branch_target, JAL_target, JALR_target;
   logic        zero, branch, memRead, memtoReg, memWrite, regWrite, branch_op, operand_B_sel;
   logic [1:0]  next_PC_sel, operand_A_sel;

   always #5 clock = ~clock;

   decode_execute_stage dut (
      .clock(clock), .reset(reset), .instruction(instruction), .PC(PC),
      .write(write), .write_reg(write_reg), .write_data(write_data), .report(report),
      .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .extend_imm(extend_imm),
      .branch_target(branch_target), .JAL_target(JAL_target), .JALR_target(JALR_target),
      .ALU_result(ALU_result), .zero(zero), .branch(branch),
      .memRead(memRead), .memtoReg(memtoReg), .memWrite(memWrite), .regWrite(regWrite),
      .branch_op(branch_op), .ALUOp(ALUOp), .next_PC_sel(next_PC_sel),
      .operand_A_sel(operand_A_sel), .operand_B_sel(operand_B_sel)
   );

   localparam int SP_NONE = 0, SP_RS1 = 1, SP_ALU = 2, SP_BR = 3, SP_BT = 4,
                  SP_JT = 5, SP_JRT = 6, SP_IMM = 7;

   typedef struct {
      logic [31:0] rs1v, rs2v, imm, alu, spot_val;
      logic [19:0] bt, jt, jrt;
      logic [6:0]  op, f7;
      logic [2:0]  f3, aluop;
      logic [4:0]  rd;
      logic [1:0]  npc, opa;
      logic        imm_care, alu_care, br, mr, m2r, mw, rw, bop, opb;
      int          spot_sel;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] mregs [32];
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic sub,
                                           input logic arith, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      int          sh;
      sh = int'(b[4:0]);
      case (f3)
         3'd0: r = sub ? a - b : a + b;
         3'd1: r = a << sh;
         3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a ^ b;
         3'd5: if (arith) r = int'(a) >>> sh; else r = a >> sh;
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return int'(a) < int'(b);
         3'd5: return int'(a) >= int'(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t predict(input logic [31:0] ins, input logic [19:0] pc);
      exp_t        e;
      logic [31:0] a, b, ii, si, ui, pc4;
      int          boff, joff;
      e = '{default: 0};
      e.op = ins[6:0]; e.f3 = ins[14:12]; e.f7 = ins[31:25]; e.rd = ins[11:7];
      a = mregs[ins[19:15]];
      b = mregs[ins[24:20]];
      e.rs1v = a; e.rs2v = b;
      ii = {{20{ins[31]}}, ins[31:20]};
      si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ui = {ins[31:12], 12'h000};
      pc4 = {12'h000, pc} + 32'd4;
      boff = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      joff = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      e.bt  = 20'(32'(pc) + boff);
      e.jt  = 20'(32'(pc) + joff);
      e.jrt = 20'((a + ii) & ~32'd1);
      e.alu_care = 1'b1;
      e.imm_care = 1'b1;
      case (ins[6:0])
         7'b0110011: begin e.rw = 1; e.aluop = 3'd0; e.imm_care = 0;
                           e.alu = alu_ref(e.f3, e.f7[5], e.f7[5], a, b); end
         7'b0010011: begin e.rw = 1; e.aluop = 3'd1; e.opb = 1; e.imm = ii;
                           e.alu = alu_ref(e.f3, 1'b0, e.f7[5], a, ii); end
         7'b0000011: begin e.rw = 1; e.mr = 1; e.m2r = 1; e.aluop = 3'd4; e.opb = 1;
                           e.imm = ii; e.alu = a + ii; end
         7'b0100011: begin e.mw = 1; e.aluop = 3'd5; e.opb = 1; e.imm = si; e.alu = a + si; end
         7'b1100011: begin e.bop = 1; e.aluop = 3'd2; e.npc = 2'b01; e.imm_care = 0;
                           e.alu = a - b; e.br = br_ref(e.f3, a, b); end
         7'b1101111: begin e.rw = 1; e.aluop = 3'd3; e.opa = 2'b01; e.npc = 2'b10;
                           e.imm_care = 0; e.alu = pc4; end
         7'b1100111: begin e.rw = 1; e.aluop = 3'd3; e.opa = 2'b01; e.npc = 2'b11;
                           e.imm = ii; e.alu = pc4; end
         7'b0110111: begin e.rw = 1; e.aluop = 3'd6; e.opa = 2'b11; e.opb = 1; e.imm = ui; e.alu = ui; end
         7'b0010111: begin e.rw = 1; e.aluop = 3'd7; e.opa = 2'b10; e.opb = 1; e.imm = ui;
                           e.alu = {12'h000, pc} + ui; end
         default:    begin e.alu_care = 0; e.imm_care = 0; end
      endcase
      return e;
   endfunction

   task automatic step(input logic [31:0] ins, input logic [19:0] pc, input logic wr,
                       input logic [4:0] wreg, input logic [31:0] wdat, input logic rst,
                       input int ssel, input logic [31:0] sval);
      exp_t e;
      instruction = ins; PC = pc; write = wr; write_reg = wreg; write_data = wdat; reset = rst;
      if (!rst) for (int i = 0; i < 32; i++) mregs[i] = '0;
      e = predict(ins, pc);
      e.spot_sel = ssel;
      e.spot_val = sval;
      sb.push_back(e);
      @(posedge clock);
      if (rst && wr && wreg != 5'd0) mregs[wreg] = wdat;
      #1;
   endtask

   always @(negedge clock) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("opcode", 32'(opcode), 32'(mon_e.op));
         check("funct3", 32'(funct3), 32'(mon_e.f3));
         check("funct7", 32'(funct7), 32'(mon_e.f7));
         check("rd", 32'(rd), 32'(mon_e.rd));
         check("rs1_data", rs1_data, mon_e.rs1v);
         check("rs2_data", rs2_data, mon_e.rs2v);
         check("branch_target", 32'(branch_target), 32'(mon_e.bt));
         check("JAL_target", 32'(JAL_target), 32'(mon_e.jt));
         check("JALR_target", 32'(JALR_target), 32'(mon_e.jrt));
         check("branch", 32'(branch), 32'(mon_e.br));
         check("ctrl_flags", 32'({memRead, memtoReg, memWrite, regWrite, branch_op}),
               32'({mon_e.mr, mon_e.m2r, mon_e.mw, mon_e.rw, mon_e.bop}));
         check("ALUOp", 32'(ALUOp), 32'(mon_e.aluop));
         check("next_PC_sel", 32'(next_PC_sel), 32'(mon_e.npc));
         check("operand_sel", 32'({operand_A_sel, operand_B_sel}), 32'({mon_e.opa, mon_e.opb}));
         if (mon_e.imm_care) check("extend_imm", extend_imm, mon_e.imm);
         if (mon_e.alu_care) begin
            check("ALU_result", ALU_result, mon_e.alu);
            check("zero", 32'(zero), 32'(mon_e.alu == 32'd0));
         end
         case (mon_e.spot_sel)
            SP_RS1: check("spot_rs1_data", rs1_data, mon_e.spot_val);
            SP_ALU: check("spot_ALU_result", ALU_result, mon_e.spot_val);
            SP_BR:  check("spot_branch", 32'(branch), mon_e.spot_val);
            SP_BT:  check("spot_branch_target", 32'(branch_target), mon_e.spot_val);
            SP_JT:  check("spot_JAL_target", 32'(JAL_target), mon_e.spot_val);
            SP_JRT: check("spot_JALR_target", 32'(JALR_target), mon_e.spot_val);
            SP_IMM: check("spot_extend_imm", extend_imm, mon_e.spot_val);
            default: ;
         endcase
      end
   end

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RD_X5    = {12'd0, 5'd5, 3'b000, 5'd0, 7'b0010011};
   localparam logic [31:0] RD_X0    = {12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011};
   localparam logic [31:0] ADD_321  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
   localparam logic [31:0] SUB_321  = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
   localparam logic [31:0] SRAI_31  = {7'b0100000, 5'd1, 5'd1, 3'b101, 5'd3, 7'b0010011};
   localparam logic [31:0] BEQ_16   = {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'b1100011};
   localparam logic [31:0] JAL_40   = {1'b0, 10'b0000100000, 1'b0, 8'd0, 5'd1, 7'b1101111};
   localparam logic [31:0] JALR_X1  = {12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111};
   localparam logic [31:0] LUI_X5   = {20'h12345, 5'd5, 7'b0110111};
   localparam logic [31:0] SW_8     = {7'd0, 5'd2, 5'd1, 3'b010, 5'b01000, 7'b0100011};
   localparam logic [31:0] BAD_OP   = 32'h0000_007F;

   logic [6:0]  ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
   logic [31:0] pats [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0004};

   initial begin
      logic [31:0] ins;
      logic [31:0] wdat;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      @(posedge clock); #1;

      step(RD_X5, 20'h0, 1'b1, 5'd5, 32'hDEAD, 1'b0, SP_RS1, 32'h0);
      step(RD_X5, 20'h0, 1'b0, 5'd0, 32'h0,    1'b1, SP_RS1, 32'h0);
      step(NOP,   20'h0, 1'b1, 5'd0, 32'd7,    1'b1, SP_NONE, 32'h0);
      step(RD_X0, 20'h0, 1'b0, 5'd0, 32'h0,    1'b1, SP_RS1, 32'h0);
      step(NOP,   20'h0, 1'b1, 5'd1, 32'd5,    1'b1, SP_NONE, 32'h0);
      step(NOP,   20'h0, 1'b1, 5'd2, 32'd3,    1'b1, SP_NONE, 32'h0);
      step(ADD_321, 20'h0, 1'b0, 5'd0, 32'h0,  1'b1, SP_ALU, 32'd8);
      step(SUB_321, 20'h0, 1'b1, 5'd1, 32'hFFFF_FFF8, 1'b1, SP_ALU, 32'd2);
      step(SRAI_31, 20'h0, 1'b1, 5'd1, 32'd4,  1'b1, SP_ALU, 32'hFFFF_FFFC);
      step(NOP,     20'h0, 1'b1, 5'd2, 32'd4,  1'b1, SP_NONE, 32'h0);
      step(BEQ_16, 20'h100, 1'b0, 5'd0, 32'h0, 1'b1, SP_BR, 32'd1);
      step(BEQ_16, 20'h100, 1'b1, 5'd2, 32'd5, 1'b1, SP_BT, 32'h110);
      step(BEQ_16, 20'h100, 1'b0, 5'd0, 32'h0, 1'b1, SP_BR, 32'd0);
      step(JAL_40, 20'h200, 1'b0, 5'd0, 32'h0, 1'b1, SP_JT, 32'h240);
      step(JAL_40, 20'h200, 1'b1, 5'd1, 32'h1001, 1'b1, SP_ALU, 32'h204);
      step(JALR_X1, 20'h0, 1'b0, 5'd0, 32'h0,  1'b1, SP_JRT, 32'h1000);
      step(LUI_X5,  20'h0, 1'b0, 5'd0, 32'h0,  1'b1, SP_ALU, 32'h1234_5000);
      step(SW_8,    20'h0, 1'b0, 5'd0, 32'h0,  1'b1, SP_IMM, 32'd8);
      step(BAD_OP,  20'h0, 1'b0, 5'd0, 32'h0,  1'b1, SP_NONE, 32'h0);

      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 9)];
         ins[19:15] = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) ins[24:20] = 5'($urandom_range(0, 7));
         wdat = ($urandom_range(0, 2) == 0) ? $urandom : pats[$urandom_range(0, 4)];
         step(ins, 20'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), wdat,
              ($urandom_range(0, 49) != 0), SP_NONE, 32'h0);
      end

      for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clock);
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
